// File: rtl/hilo_muldiv_if.sv
// Start/Busy/Done request channel between the Execution stage and the Hi/Lo
// multiply/divide unit, plus the architectural Hi/Lo result pair.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             Busy;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, OperandA, OperandB,
        input  Busy, Done, DivByZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, OperandA, OperandB,
        output Busy, Done, DivByZero, Hi, Lo
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the Hi/Lo registers. Works on
// operand magnitudes (shift-add / restoring division) and fixes signs afterwards.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         Clk,
    input  logic         Rst,
    hilo_muldiv_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               zero_q, zero_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Signed ops have Op[0]==0; the magnitude of the most negative value wraps to itself,
    // which is exactly the unsigned magnitude the iterative datapath needs.
    always_comb begin
        sign_a = ~bus.Op[0] & bus.OperandA[WIDTH-1];
        sign_b = ~bus.Op[0] & bus.OperandB[WIDTH-1];
        mag_a  = sign_a ? ({WIDTH{1'b0}} - bus.OperandA) : bus.OperandA;
        mag_b  = sign_b ? ({WIDTH{1'b0}} - bus.OperandB) : bus.OperandB;
    end

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_trial = div_shift - {1'b0, opnd_q};
        div_next  = div_trial[WIDTH]
                  ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                  : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        prod_fix  = neg_lo_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
        quo_fix   = neg_lo_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_fix   = neg_hi_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        zero_d   = zero_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.Start) begin
                    is_div_d = bus.Op[1];
                    neg_lo_d = sign_a ^ sign_b;
                    neg_hi_d = bus.Op[1] ? sign_a : (sign_a ^ sign_b);
                    zero_d   = bus.Op[1] && (bus.OperandB == {WIDTH{1'b0}});
                    cnt_d    = {CW{1'b0}};
                    acc_d    = {{WIDTH{1'b0}}, (bus.Op[1] ? mag_a : mag_b)};
                    opnd_d   = bus.Op[1] ? mag_b : mag_a;
                    state_d  = zero_d ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                if (!zero_q) begin
                    hi_d = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered copies of the state being entered.
        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
        dbz_d  = (state_d == S_DONE) && zero_d;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            zero_q   <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            zero_q   <= zero_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.DivByZero = dbz_q;
    assign bus.Hi        = hi_q;
    assign bus.Lo        = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized self-checking bench for hilo_muldiv_unit against a 64-bit arithmetic model.
module tb_hilo_muldiv_unit;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] ref_hilo = 64'd0;

    hilo_muldiv_if #(.WIDTH(32)) bus ();

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {Hi, Lo} from plain integer arithmetic; zero divisor keeps the old pair.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] prev);
        longint sa, sb, q, r, p;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = prev;
        case (op)
            2'b00: begin p = sa * sb; res = p; end
            2'b01: res = {32'd0, a} * {32'd0, b};
            2'b10: if (b != 32'd0) begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            default: if (b != 32'd0) res = {a % b, a / b};
        endcase
        return res;
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
        return (op[1] && b == 32'd0) ? 2 : 34;
    endfunction

    // Caller is at a falling edge; returns at the falling edge of cycle 1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Op       = op;
        bus.OperandA = a;
        bus.OperandB = b;
        bus.Start    = 1'b1;
        @(negedge clk);
        bus.Start    = 1'b0;
        bus.Op       = 2'($urandom);
        bus.OperandA = $urandom;
        bus.OperandB = $urandom;
    endtask

    task automatic wait_done(output int lat, output int busy_n, output logic dbz,
                             output logic [31:0] hi, output logic [31:0] lo);
        lat = -1; busy_n = 0; dbz = 1'bx; hi = 'x; lo = 'x;
        for (int c = 1; c <= 100; c++) begin
            if (bus.Done === 1'b1) begin
                lat = c; dbz = bus.DivByZero; hi = bus.Hi; lo = bus.Lo;
                break;
            end
            if (bus.Busy === 1'b1) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.Start = 1'b0; bus.Op = 2'b00; bus.OperandA = '0; bus.OperandB = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
        checks++; if (bus.DivByZero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", bus.DivByZero); end
        checks++; if (bus.Hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.Hi); end
        checks++; if (bus.Lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.Lo); end
        rst = 1'b0;
        ref_hilo = 64'd0;
        @(negedge clk);
        $display("reset: hi=%h lo=%h", bus.Hi, bus.Lo);
    endtask

    task automatic test_mult_basic();
        int lat, bn; logic dbz; logic [31:0] hi, lo;
        issue(2'b00, 32'h00000007, 32'hFFFFFFFD);
        wait_done(lat, bn, dbz, hi, lo);
        ref_hilo = 64'hFFFFFFFF_FFFFFFEB;
        checks++; if (lat !== 34) begin errors++; $display("FAIL mult_latency got=%0d exp=34", lat); end
        checks++; if (bn !== 33) begin errors++; $display("FAIL mult_busy_cycles got=%0d exp=33", bn); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done got=%b exp=0", bus.Busy); end
        checks++; if ({hi, lo} !== ref_hilo) begin errors++; $display("FAIL mult_result got=%h_%h exp=%h", hi, lo, ref_hilo); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL mult_dbz got=%b exp=0", dbz); end
        $display("MULT 7 x -3: lat=%0d hi=%h lo=%h", lat, hi, lo);
        @(negedge clk);
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got=%b exp=0", bus.Done); end
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, bn, dbz, hi, lo);
        ref_hilo = 64'hFFFFFFFE_00000001;
        checks++; if ({hi, lo} !== ref_hilo) begin errors++; $display("FAIL multu_max got=%h_%h exp=%h", hi, lo, ref_hilo); end
        $display("MULTU ffffffff^2: lat=%0d hi=%h lo=%h", lat, hi, lo);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bn; logic dbz; logic [31:0] hi, lo;
        issue(2'b10, 32'hFFFFFFF9, 32'h00000002);
        wait_done(lat, bn, dbz, hi, lo);
        ref_hilo = {32'hFFFFFFFF, 32'hFFFFFFFD};
        checks++; if ({hi, lo} !== ref_hilo) begin errors++; $display("FAIL div_neg got=%h_%h exp=%h", hi, lo, ref_hilo); end
        $display("DIV -7/2: lat=%0d hi=%h lo=%h", lat, hi, lo);
        issue(2'b11, 32'd100, 32'd7);
        wait_done(lat, bn, dbz, hi, lo);
        ref_hilo = {32'd2, 32'd14};
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
        checks++; if ({hi, lo} !== ref_hilo) begin errors++; $display("FAIL b2b_divu got=%h_%h exp=%h", hi, lo, ref_hilo); end
        $display("DIVU 100/7 back-to-back: lat=%0d hi=%0d lo=%0d", lat, hi, lo);
        @(negedge clk);
    endtask

    task automatic test_div_by_zero();
        int lat, bn; logic dbz; logic [31:0] hi, lo;
        issue(2'b11, 32'd47, 32'd7);
        wait_done(lat, bn, dbz, hi, lo);
        ref_hilo = {32'd5, 32'd6};
        checks++; if ({hi, lo} !== ref_hilo) begin errors++; $display("FAIL preload got=%h_%h exp=%h", hi, lo, ref_hilo); end
        @(negedge clk);
        issue(2'b11, 32'd100, 32'd0);
        wait_done(lat, bn, dbz, hi, lo);
        checks++; if (lat !== 2) begin errors++; $display("FAIL dbz_latency got=%0d exp=2", lat); end
        checks++; if (bn !== 1) begin errors++; $display("FAIL dbz_busy_cycles got=%0d exp=1", bn); end
        checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dbz_flag got=%b exp=1", dbz); end
        checks++; if ({hi, lo} !== ref_hilo) begin errors++; $display("FAIL dbz_hold got=%h_%h exp=%h", hi, lo, ref_hilo); end
        $display("DIVU 100/0: lat=%0d dbz=%b hi=%0d lo=%0d", lat, dbz, hi, lo);
        @(negedge clk);
        checks++; if (bus.DivByZero !== 1'b0) begin errors++; $display("FAIL dbz_pulse got=%b exp=0", bus.DivByZero); end
    endtask

    task automatic test_ignored_start();
        int n_done = 0, lat = -1;
        logic [31:0] hi = '0, lo = '0;
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) begin
                bus.Op = 2'b01; bus.OperandA = 32'd9; bus.OperandB = 32'd9; bus.Start = 1'b1;
            end else begin
                bus.Start = 1'b0;
            end
            if (bus.Done === 1'b1) begin
                n_done++;
                if (lat < 0) begin lat = c; hi = bus.Hi; lo = bus.Lo; end
            end
            @(negedge clk);
        end
        bus.Start = 1'b0;
        ref_hilo = {32'd0, 32'h80000000};
        checks++; if (n_done !== 1) begin errors++; $display("FAIL ignore_start_dones got=%0d exp=1", n_done); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL overflow_latency got=%0d exp=34", lat); end
        checks++; if ({hi, lo} !== ref_hilo) begin errors++; $display("FAIL div_overflow got=%h_%h exp=%h", hi, lo, ref_hilo); end
        $display("DIV 80000000/-1 with stray Start: dones=%0d hi=%h lo=%h", n_done, hi, lo);
    endtask

    task automatic test_reset_mid_op();
        int n_done = 0, lat, bn; logic dbz; logic [31:0] hi, lo;
        issue(2'b00, 32'h12345678, 32'h9ABCDEF0);
        repeat (14) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got=%b exp=0", bus.Busy); end
        checks++; if (bus.Hi !== 32'd0) begin errors++; $display("FAIL async_rst_hi got=%h exp=0", bus.Hi); end
        checks++; if (bus.Lo !== 32'd0) begin errors++; $display("FAIL async_rst_lo got=%h exp=0", bus.Lo); end
        @(negedge clk);
        rst = 1'b0;
        ref_hilo = 64'd0;
        for (int c = 0; c < 40; c++) begin
            if (bus.Done === 1'b1) n_done++;
            @(negedge clk);
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL rst_no_done got=%0d exp=0", n_done); end
        issue(2'b00, 32'd3, 32'd4);
        wait_done(lat, bn, dbz, hi, lo);
        ref_hilo = 64'd12;
        checks++; if ({hi, lo} !== ref_hilo) begin errors++; $display("FAIL post_rst_mult got=%h_%h exp=%h", hi, lo, ref_hilo); end
        $display("MULT 3x4 after reset: lat=%0d hi=%h lo=%h", lat, hi, lo);
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, bn; logic dbz; logic [31:0] hi, lo, a, b;
        logic [1:0] op;
        logic [63:0] exp_v;
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom);
            a  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom >> $urandom_range(0, 31);
            exp_v = model(op, a, b, ref_hilo);
            issue(op, a, b);
            wait_done(lat, bn, dbz, hi, lo);
            checks++; if (lat !== exp_lat(op, b)) begin errors++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, exp_lat(op, b)); end
            checks++; if ({hi, lo} !== exp_v) begin errors++; $display("FAIL rand%0d_result op=%0d a=%h b=%h got=%h_%h exp=%h", i, op, a, b, hi, lo, exp_v); end
            checks++; if (dbz !== (op[1] && b == 32'd0)) begin errors++; $display("FAIL rand%0d_dbz got=%b", i, dbz); end
            $display("rand%0d op=%0d a=%h b=%h -> lat=%0d hi=%h lo=%h", i, op, a, b, lat, hi, lo);
            ref_hilo = exp_v;
            // Randomly chain the next request into the Done cycle.
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_back_to_back();
        test_div_by_zero();
        test_ignored_start();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
